// File: rtl/fetch_controller_if.sv
// fetch_controller_if: bus bundle between the fetch controller, instruction
// memory, decode and execute.
//
// Handshake rule (applies to imem_req, imem_rsp, inst and redirect):
//   a transfer happens on a rising clk edge where valid (and ready, where a
//   ready exists) are both high. A valid source holds its payload stable until
//   the transfer. imem_rsp and redirect have no ready: they transfer on every
//   cycle their valid is high. The memory returns exactly one response per
//   accepted request, no earlier than the cycle after acceptance.
//
// Signals:
//   imem_req_valid/ready, imem_addr  fetch request towards imem
//   imem_rsp_valid, imem_rsp_data    instruction word back from imem
//   inst_valid/ready, inst_data/pc   held instruction towards decode
//   redirect_valid, redirect_pc      taken branch/jump from execute
// Modports: master = fetch controller, slave = its environment.
interface fetch_controller_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            inst_valid;
  logic [31:0]     inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_controller.sv
// fetch_controller: KLP32 program counter and instruction fetch sequencer.
// Owns the PC, keeps at most one imem request outstanding, holds each fetched
// word until decode takes it, and applies redirects from execute (flushing
// any fetch already in flight).
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   bus (master)     imem request/response, decode instruction, redirect
//   pc_out           current fetch PC
//   misaligned_err   sticky until reset: a redirect target was not 4-byte aligned
//   state_dbg        current FSM state (REQ=0, WAIT=1, HOLD=2, DRAIN=3, ERR=4)
module fetch_controller #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic               clk,
  input  logic               reset,
  fetch_controller_if.master bus,
  output logic [XLEN-1:0]    pc_out,
  output logic               misaligned_err,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pc_q;
  logic            inst_valid_q;
  logic [31:0]     inst_data_q;
  logic [XLEN-1:0] inst_pc_q;
  logic            err_q;

  logic redir_ok;
  logic redir_bad;
  logic rsp_take;
  logic consume;

  // Redirect outranks every other event, so response capture and decode
  // consumption are both suppressed in a redirect cycle.
  always_comb begin
    redir_ok  = bus.redirect_valid && (bus.redirect_pc[1:0] == 2'b00);
    redir_bad = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    rsp_take  = (state == S_WAIT) && bus.imem_rsp_valid && !bus.redirect_valid;
    consume   = (state == S_HOLD) && bus.inst_ready && !bus.redirect_valid;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_REQ;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      S_REQ: begin
        if (redir_bad) begin
          state_next = S_ERR;
        end else if (redir_ok) begin
          // A request accepted this same cycle still targets the old PC and
          // its response must be thrown away.
          state_next = bus.imem_req_ready ? S_DRAIN : S_REQ;
        end else if (bus.imem_req_ready) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redir_bad) begin
          state_next = S_ERR;
        end else if (redir_ok) begin
          state_next = bus.imem_rsp_valid ? S_REQ : S_DRAIN;
        end else if (bus.imem_rsp_valid) begin
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redir_bad) begin
          state_next = S_ERR;
        end else if (redir_ok || bus.inst_ready) begin
          state_next = S_REQ;
        end
      end
      S_DRAIN: begin
        if (redir_bad) begin
          state_next = S_ERR;
        end else if (bus.imem_rsp_valid) begin
          // The stale response is consumed here whether or not a new
          // redirect arrives alongside it.
          state_next = S_REQ;
        end
      end
      S_ERR: begin
        state_next = S_ERR;
      end
      default: begin
        state_next = S_REQ;
      end
    endcase
  end

  // PC, held instruction and error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_VECTOR;
      inst_valid_q <= 1'b0;
      inst_data_q  <= 32'd0;
      inst_pc_q    <= '0;
      err_q        <= 1'b0;
    end else if (state != S_ERR) begin
      if (redir_bad) begin
        err_q        <= 1'b1;
        inst_valid_q <= 1'b0;
      end else if (redir_ok) begin
        pc_q         <= bus.redirect_pc;
        inst_valid_q <= 1'b0;
      end else if (rsp_take) begin
        inst_valid_q <= 1'b1;
        inst_data_q  <= bus.imem_rsp_data;
        inst_pc_q    <= pc_q;
      end else if (consume) begin
        // Natural modulo-2^XLEN wrap from the top word back to zero.
        pc_q         <= pc_q + XLEN'(4);
        inst_valid_q <= 1'b0;
      end
    end
  end

  // Outputs
  always_comb begin
    bus.imem_req_valid = (state == S_REQ);
    bus.imem_addr      = pc_q;
    bus.inst_valid     = inst_valid_q;
    bus.inst_data      = inst_data_q;
    bus.inst_pc        = inst_pc_q;
    pc_out             = pc_q;
    misaligned_err     = err_q;
    state_dbg          = state;
  end

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

  localparam int unsigned XLEN         = 32;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_out;
  logic        misaligned_err;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  fetch_controller_if #(.XLEN(XLEN)) fc();

  fetch_controller #(.XLEN(XLEN), .RESET_VECTOR(RESET_VECTOR)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (fc),
    .pc_out         (pc_out),
    .misaligned_err (misaligned_err),
    .state_dbg      (state_dbg)
  );

  // ---------------- scoreboard / model state ----------------
  int          n_vec      = 0;
  int          n_err      = 0;
  int          n_consumed = 0;
  logic [63:0] exp_q[$];               // {pc, data} in program order
  logic [31:0] exp_pc     = RESET_VECTOR; // next instruction decode should see
  bit          in_err     = 1'b0;

  // imem responder knobs and state
  int          ready_pct     = 100;
  int          rsp_min       = 0;
  int          rsp_max       = 0;
  bit          override_next = 1'b0;
  logic [31:0] override_val  = 32'h0;
  bit          pending       = 1'b0;
  logic [31:0] pend_addr     = 32'h0;
  int          pend_delay    = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_rd = 32'h0051_0193;
      32'h0000_0004: mem_rd = 32'h0010_0093;
      32'h0000_0008: mem_rd = 32'h0020_81b3;
      default:       mem_rd = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out", name);
  endtask

  // ---------------- imem responder ----------------
  initial begin : imem_model
    bit          hs;
    bit          rsp_seen;
    logic [31:0] hs_addr;
    fc.imem_req_ready = 1'b0;
    fc.imem_rsp_valid = 1'b0;
    fc.imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      hs       = !reset && fc.imem_req_valid && fc.imem_req_ready;
      hs_addr  = fc.imem_addr;
      rsp_seen = fc.imem_rsp_valid;
      @(posedge clk);
      #1;
      fc.imem_rsp_valid = 1'b0;
      if (rsp_seen) pending = 1'b0;
      if (hs) begin
        pending    = 1'b1;
        pend_addr  = hs_addr;
        pend_delay = $urandom_range(rsp_max, rsp_min);
      end
      if (pending) begin
        if (pend_delay == 0) begin
          fc.imem_rsp_valid = 1'b1;
          fc.imem_rsp_data  = override_next ? override_val : mem_rd(pend_addr);
          override_next     = 1'b0;
        end else begin
          pend_delay--;
        end
      end
      fc.imem_req_ready = !pending && ($urandom_range(99, 0) < ready_pct);
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (fc.inst_valid && fc.inst_ready && !fc.redirect_valid) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_inst: got pc %h, no instruction expected", fc.inst_pc);
          end else begin
            e = exp_q.pop_front();
            chk("inst_pc", fc.inst_pc, e[63:32]);
            chk("inst_data", fc.inst_data, e[31:0]);
            n_consumed++;
          end
        end
        if (fc.imem_req_valid && !fc.redirect_valid && !in_err)
          chk("imem_addr", fc.imem_addr, exp_pc);
      end
    end
  end

  // ---------------- drivers ----------------
  // One cycle of decode/execute stimulus; the model advances on what will
  // happen at the coming edge.
  task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc);
    @(posedge clk);
    #2;
    fc.inst_ready     = rdy;
    fc.redirect_valid = rv;
    fc.redirect_pc    = rpc;
    if (!reset && !in_err) begin
      if (rv) begin
        if (rpc[1:0] == 2'b00) exp_pc = rpc;
        else in_err = 1'b1;
      end else if (fc.inst_valid && rdy) begin
        exp_q.push_back({exp_pc, mem_rd(exp_pc)});
        exp_pc = exp_pc + 32'd4;
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #2;
    reset             = 1'b1;
    fc.inst_ready     = 1'b0;
    fc.redirect_valid = 1'b0;
    fc.redirect_pc    = 32'h0;
    exp_pc            = RESET_VECTOR;
    in_err            = 1'b0;
    repeat (cycles) @(posedge clk);
    #2;
    chk("rst_inst_valid", fc.inst_valid, 32'd0);
    chk("rst_inst_data", fc.inst_data, 32'd0);
    chk("rst_inst_pc", fc.inst_pc, 32'd0);
    chk("rst_err", misaligned_err, 32'd0);
    chk("rst_pc_out", pc_out, RESET_VECTOR);
    chk("rst_req_valid", fc.imem_req_valid, 32'd1);
    reset = 1'b0;
  endtask

  task automatic wait_inst(input int budget, input string name);
    int k = 0;
    while (!fc.inst_valid && k < budget) begin
      step(1'b0, 1'b0, 32'h0);
      k++;
    end
    if (!fc.inst_valid) timeout_fail(name);
  endtask

  task automatic consume_n(input int n, input int budget, input string name);
    int target = n_consumed + n;
    int k = 0;
    while (n_consumed < target && k < budget) begin
      step(1'b1, 1'b0, 32'h0);
      k++;
    end
    if (n_consumed < target) timeout_fail(name);
  endtask

  task automatic wait_pending(input int budget, input string name);
    int k = 0;
    while (!pending && k < budget) begin
      step(1'b0, 1'b0, 32'h0);
      k++;
    end
    if (!pending) timeout_fail(name);
  endtask

  task automatic wait_req(input int budget, input string name);
    int k = 0;
    while (!fc.imem_req_valid && k < budget) begin
      step(1'b0, 1'b0, 32'h0);
      k++;
    end
    if (!fc.imem_req_valid) timeout_fail(name);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [31:0] p;
    int          r;
    fc.inst_ready     = 1'b0;
    fc.redirect_valid = 1'b0;
    fc.redirect_pc    = 32'h0;

    // 1: straight-line fetch, fastest memory and decode
    ready_pct = 100; rsp_min = 0; rsp_max = 0;
    do_reset(2);
    consume_n(3, 40, "t1_stream");

    // 2: decode stall holds everything in place
    wait_inst(20, "t2_wait");
    p = exp_pc;
    repeat (5) begin
      step(1'b0, 1'b0, 32'h0);
      chk("t2_inst_valid", fc.inst_valid, 32'd1);
      chk("t2_inst_pc", fc.inst_pc, p);
      chk("t2_inst_data", fc.inst_data, mem_rd(p));
      chk("t2_req_valid", fc.imem_req_valid, 32'd0);
      chk("t2_pc_out", pc_out, p);
    end
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("t2_pc_adv", pc_out, p + 32'd4);

    // 3: redirect while waiting on imem; the late word must be dropped
    rsp_min = 3; rsp_max = 3;
    wait_pending(20, "t3_pending");
    override_val  = 32'h7676_7676;
    override_next = 1'b1;
    step(1'b0, 1'b1, 32'h0000_0100);
    rsp_min = 0; rsp_max = 0;
    wait_req(20, "t3_req");
    chk("t3_req_addr", fc.imem_addr, 32'h0000_0100);
    consume_n(1, 30, "t3_consume");

    // 4: redirect and decode-ready together in HOLD
    wait_inst(30, "t4_wait");
    step(1'b1, 1'b1, 32'h0000_0200);
    consume_n(2, 40, "t4_consume");

    // 5: misaligned redirect parks the block until reset
    p = exp_pc;
    step(1'b0, 1'b1, 32'h0000_0102);
    step(1'b0, 1'b0, 32'h0);
    chk("t5_err", misaligned_err, 32'd1);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, k == 3, 32'h0000_0300);
      chk("t5_req_valid", fc.imem_req_valid, 32'd0);
      chk("t5_inst_valid", fc.inst_valid, 32'd0);
      chk("t5_err_sticky", misaligned_err, 32'd1);
      chk("t5_pc_kept", pc_out, p);
    end
    do_reset(2);
    consume_n(2, 40, "t5_resume");

    // 6: wrap past the top of the address space, then reset mid-WAIT
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    consume_n(1, 30, "t6_top");
    wait_req(20, "t6_req");
    chk("t6_wrap_addr", fc.imem_addr, 32'h0000_0000);
    rsp_min = 3; rsp_max = 3;
    wait_pending(20, "t6_pending");
    override_val  = 32'hDEAD_BEEF;
    override_next = 1'b1;
    do_reset(1);
    rsp_min = 0; rsp_max = 0;
    consume_n(2, 40, "t6_after_reset");

    // random traffic
    ready_pct = 70; rsp_min = 0; rsp_max = 3;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(99, 0);
      if (r < 1) begin
        do_reset($urandom_range(3, 1));
      end else if (r < 6) begin
        step(1'($urandom_range(1, 0)), 1'b1,
             (r == 5) ? 32'hFFFF_FFF8 : (32'($urandom_range(255, 0)) << 2));
      end else if (r < 7 && ($urandom_range(9, 0) == 0)) begin
        step(1'b0, 1'b1, (32'($urandom_range(255, 0)) << 2) | 32'($urandom_range(3, 1)));
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        chk("rand_err", misaligned_err, 32'd1);
        do_reset(1);
      end else begin
        step($urandom_range(99, 0) < 60, 1'b0, 32'h0);
      end
    end

    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("sb_empty", exp_q.size(), 32'd0);
    chk("progress", n_consumed > 200, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
